// File: rtl/loba_operand_split_pipe_if.sv
// loba_operand_split_pipe_if: operand-in / split-result-out handshake bundle
interface loba_operand_split_pipe_if #(parameter int N = 16, parameter int M = 4);
    localparam int K = $clog2(N);
    logic in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0] A, B;
    logic [M-1:0] Ah, Al, Bh, Bl;
    logic [K-1:0] k1a, k2a, k1b, k2b;
    logic exact_a, exact_b;
    modport master(output in_valid, A, B, out_ready,
                   input in_ready, out_valid, Ah, Al, Bh, Bl, k1a, k2a, k1b, k2b, exact_a, exact_b);
    modport slave(input in_valid, A, B, out_ready,
                  output in_ready, out_valid, Ah, Al, Bh, Bl, k1a, k2a, k1b, k2b, exact_a, exact_b);
endinterface

// File: rtl/loba_operand_split_pipe.sv
// loba_operand_split_pipe: two-stage leading-one split of an operand pair into high/low segments
module loba_operand_split_pipe #(parameter int N = 16, parameter int M = 4) (
    input logic clk,
    input logic rst,
    loba_operand_split_pipe_if.slave bus
);
    localparam int K = $clog2(N);

    // Only bits at or above M can move k past M-1; values below that share k = M-1.
    function automatic logic [K-1:0] lod(input logic [N-1:0] v);
        lod = K'(M-1);
        for (int i = M; i < N; i++) if (v[i]) lod = K'(i);
    endfunction

    function automatic logic [M-1:0] seg(input logic [N-1:0] v, input logic [K-1:0] k);
        seg = M'(v >> (k - K'(M-1)));
    endfunction

    function automatic logic [N-1:0] low(input logic [N-1:0] v, input logic [K-1:0] k);
        low = v & ((N'(1) << (k - K'(M-1))) - N'(1));
    endfunction

    logic s1_valid, s2_valid, s1_load, s2_load;
    logic [N-1:0] a1, b1, ra, rb;
    logic [M-1:0] ah, bh;
    logic [K-1:0] k1a, k1b, k1a_c, k1b_c;

    assign s2_load = !s2_valid || bus.out_ready;
    assign s1_load = !s1_valid || s2_load;
    assign bus.in_ready = s1_load;
    assign k1a_c = lod(a1);
    assign k1b_c = lod(b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            a1 <= '0;
            b1 <= '0;
            ra <= '0;
            rb <= '0;
            ah <= '0;
            bh <= '0;
            k1a <= K'(M-1);
            k1b <= K'(M-1);
        end else begin
            if (s1_load) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    a1 <= bus.A;
                    b1 <= bus.B;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    ah <= seg(a1, k1a_c);
                    bh <= seg(b1, k1b_c);
                    k1a <= k1a_c;
                    k1b <= k1b_c;
                    ra <= low(a1, k1a_c);
                    rb <= low(b1, k1b_c);
                end
            end
        end
    end

    // Low segments derive from the registered remainders, so reset (R = 0) yields seg 0, k = M-1, exact.
    assign bus.out_valid = s2_valid;
    assign bus.Ah = ah;
    assign bus.Bh = bh;
    assign bus.k1a = k1a;
    assign bus.k1b = k1b;
    assign bus.k2a = lod(ra);
    assign bus.k2b = lod(rb);
    assign bus.Al = seg(ra, bus.k2a);
    assign bus.Bl = seg(rb, bus.k2b);
    assign bus.exact_a = low(ra, bus.k2a) == '0;
    assign bus.exact_b = low(rb, bus.k2b) == '0;
endmodule

// File: tb/tb_loba_operand_split_pipe.sv
// tb_loba_operand_split_pipe: table-driven checks of the operand split pipeline
module tb_loba_operand_split_pipe;
    typedef struct {
        logic [15:0] x;
        logic [3:0]  h;
        logic [3:0]  kh;
        logic [3:0]  l;
        logic [3:0]  kl;
        logic        e;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int q[$];
    op_t ops[13];

    loba_operand_split_pipe_if #(.N(16), .M(4)) bus();
    loba_operand_split_pipe #(.N(16), .M(4)) dut(.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic logic [33:0] expv(int ia, int ib);
        return {ops[ia].h, ops[ia].kh, ops[ia].l, ops[ia].kl, ops[ia].e,
                ops[ib].h, ops[ib].kh, ops[ib].l, ops[ib].kl, ops[ib].e};
    endfunction

    function automatic logic [33:0] actv();
        return {bus.Ah, bus.k1a, bus.Al, bus.k2a, bus.exact_a,
                bus.Bh, bus.k1b, bus.Bl, bus.k2b, bus.exact_b};
    endfunction

    task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle from a negedge: drive, score the handshakes the next posedge will perform, step.
    task automatic cyc(input logic v, input int ia, input int ib, input logic ordy, output logic ir);
        bus.in_valid = v;
        bus.A = ops[ia].x;
        bus.B = ops[ib].x;
        bus.out_ready = ordy;
        #1;
        ir = bus.in_ready;
        if (bus.out_valid) begin
            if (q.size() == 0) chk("spurious_out", 34'(bus.out_valid), 34'd0);
            else begin
                chk(ordy ? "xfer" : "hold", actv(), expv(q[0] / 16, q[0] % 16));
                if (ordy) void'(q.pop_front());
            end
        end
        if (v && ir) q.push_back(ia * 16 + ib);
        @(negedge clk);
    endtask

    task automatic drain();
        logic ir;
        int n = 0;
        while (q.size() > 0 && n < 20) begin
            cyc(1'b0, 4, 4, 1'b1, ir);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results missing, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic ir;
        ops[0]  = '{16'h8000, 4'h8, 4'd15, 4'h0, 4'd3,  1'b1};
        ops[1]  = '{16'h0005, 4'h5, 4'd3,  4'h0, 4'd3,  1'b1};
        ops[2]  = '{16'h1234, 4'h9, 4'd12, 4'hD, 4'd5,  1'b1};
        ops[3]  = '{16'hFFFF, 4'hF, 4'd15, 4'hF, 4'd11, 1'b0};
        ops[4]  = '{16'h0000, 4'h0, 4'd3,  4'h0, 4'd3,  1'b1};
        ops[5]  = '{16'h000F, 4'hF, 4'd3,  4'h0, 4'd3,  1'b1};
        ops[6]  = '{16'h0010, 4'h8, 4'd4,  4'h0, 4'd3,  1'b1};
        ops[7]  = '{16'h0011, 4'h8, 4'd4,  4'h1, 4'd3,  1'b1};
        ops[8]  = '{16'h00FF, 4'hF, 4'd7,  4'hF, 4'd3,  1'b1};
        ops[9]  = '{16'h01FF, 4'hF, 4'd8,  4'hF, 4'd4,  1'b0};
        ops[10] = '{16'hA5A5, 4'hA, 4'd15, 4'hB, 4'd10, 1'b0};
        ops[11] = '{16'h0300, 4'hC, 4'd9,  4'h0, 4'd3,  1'b1};
        ops[12] = '{16'h4001, 4'h8, 4'd14, 4'h1, 4'd3,  1'b1};
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.out_ready = 1'b1;
        #12;
        chk("reset_out_valid", 34'(bus.out_valid), 34'd0);
        chk("reset_fields", actv(), expv(4, 4));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 34'(bus.in_ready), 34'd1);
        @(negedge clk);
        // Spot vectors, then an all-zero pair checked for exact two-cycle latency.
        cyc(1'b1, 0, 1, 1'b1, ir);
        cyc(1'b1, 2, 3, 1'b1, ir);
        drain();
        cyc(1'b1, 4, 4, 1'b1, ir);
        bus.in_valid = 1'b0;
        #1;
        chk("latency_early", 34'(bus.out_valid), 34'd0);
        @(negedge clk);
        chk("latency_t2", 34'(bus.out_valid), 34'd1);
        drain();
        // Back-to-back stream across the table, no stalls.
        for (int i = 0; i < 13; i++) begin
            cyc(1'b1, i, (i + 5) % 13, 1'b1, ir);
            chk("stream_in_ready", 34'(ir), 34'd1);
            if (i >= 1) chk("stream_out_valid", 34'(bus.out_valid), 34'd1);
        end
        drain();
        // Stream with a five-cycle downstream stall.
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, (i * 3) % 13, (i + 7) % 13, !(i >= 3 && i <= 7), ir);
            if (i >= 3 && i <= 7) chk("stall_in_ready", 34'(ir), 34'd0);
        end
        drain();
        // Fill both stages, then reset asynchronously mid-stall.
        cyc(1'b1, 5, 6, 1'b0, ir);
        cyc(1'b1, 7, 8, 1'b0, ir);
        cyc(1'b1, 9, 10, 1'b0, ir);
        chk("full_in_ready", 34'(ir), 34'd0);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 34'(bus.out_valid), 34'd0);
        chk("async_rst_fields", actv(), expv(4, 4));
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 11, 12, 1'b1, ir);
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
